alu_exec_unit: RTL and testbench

//   Parametrised successor to the 12-bit ALU plus 8-entry register file pair: one clocked

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_seq_mul.sv | 56 +++++
 rtl/alu_exec_unit.sv | 183 ++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and FSM encodings for the execution unit and its bench.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_MUL = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_SLL = 3'b110,
    OP_SRL = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2
  } state_t;

  // MUL is the only opcode that takes the multi-cycle path
  function automatic logic is_mul(input op_t op);
    return (op == OP_MUL);
  endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative unsigned shift-add multiplier, one multiplier bit consumed per cycle.
// Latency: start at edge T, final product valid on 'product' during cycle T+W (done=1 then).
// Backpressure: start is ignored while busy; the caller must wait for busy to drop.
module alu_seq_mul #(
  parameter int W = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int CW = $clog2(W + 1);

  logic [2*W-1:0] mcand;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] addend;
  logic [W-1:0]   mplier;
  logic [CW-1:0]  cnt;

  // Partial product for the multiplier bit being consumed this cycle
  always_comb begin
    addend = '0;
    if (mplier[0]) addend = mcand;
  end

  // 'product' already includes the current step, so on the last busy cycle it is final
  assign product = acc + addend;
  assign busy    = (cnt != '0);
  assign done    = (cnt == CW'(1));

  // Operand load on start, then one shift-add step per busy cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (start && !busy) begin
      mcand  <= {{W{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
      cnt    <= CW'(W);
    end else if (busy) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Register file plus ALU executing reg-to-reg ops; optional flags via `ALU_FLAGS_EN.
// Latency: accept at edge T; non-MUL writes rd at T+1 (done in T+2), MUL writes at T+W (done in T+W+1).
// Backpressure: in_ready is low while an op is in flight; in_valid is simply held off until idle.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter  int W    = 12,
  parameter  int NREG = 8,
  localparam int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          init_we,
  input  logic [AW-1:0] init_addr,
  input  logic [W-1:0]  init_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_opcode,
  input  logic [AW-1:0] in_rs1,
  input  logic [AW-1:0] in_rs2,
  input  logic [AW-1:0] in_rd,
  input  logic [AW-1:0] dbg_addr,
  output logic [W-1:0]  dbg_data,
  output logic          done
`ifdef ALU_FLAGS_EN
  ,
  output logic          flag_z,
  output logic          flag_c,
  output logic          flag_v
`endif
);

  state_t         state;
  state_t         state_nxt;
  logic [W-1:0]   regs [NREG];
  logic [W-1:0]   opa;
  logic [W-1:0]   opb;
  op_t            op_q;
  logic [AW-1:0]  rd_q;
  logic           accept;
  logic           wb_en;
  logic [W-1:0]   alu_res;
  logic           mul_start;
  logic           mul_busy;
  logic           mul_done;
  logic [2*W-1:0] mul_product;
  logic           unused_mul_busy;

  assign in_ready  = (state == S_IDLE);
  assign accept    = in_valid && in_ready;
  assign dbg_data  = regs[dbg_addr];
  assign mul_start = accept && is_mul(op_t'(in_opcode));

  // FSM sequences completion through wb_en rather than mul_busy
  assign unused_mul_busy = mul_busy;

  alu_seq_mul #(.W(W)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (regs[in_rs1]),
    .b       (regs[in_rs2]),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state and writeback strobe
  always_comb begin
    state_nxt = state;
    wb_en     = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = is_mul(op_t'(in_opcode)) ? S_MUL : S_EXEC;
      end
      S_EXEC: begin
        wb_en     = 1'b1;
        state_nxt = S_IDLE;
      end
      S_MUL: begin
        if (mul_done) begin
          wb_en     = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operands are captured at accept, so a same-edge init write or rd==rs alias cannot disturb them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa  <= '0;
      opb  <= '0;
      op_q <= OP_ADD;
      rd_q <= '0;
    end else if (accept) begin
      opa  <= regs[in_rs1];
      opb  <= regs[in_rs2];
      op_q <= op_t'(in_opcode);
      rd_q <= in_rd;
    end
  end

  // Result mux; logical shifts by B >= W naturally yield zero
  always_comb begin
    alu_res = '0;
    case (op_q)
      OP_ADD:  alu_res = opa + opb;
      OP_SUB:  alu_res = opa - opb;
      OP_AND:  alu_res = opa & opb;
      OP_MUL:  alu_res = mul_product[W-1:0];
      OP_OR:   alu_res = opa | opb;
      OP_XOR:  alu_res = opa ^ opb;
      OP_SLL:  alu_res = opa << opb;
      OP_SRL:  alu_res = opa >> opb;
      default: alu_res = '0;
    endcase
  end

  // Register file: writeback only when busy, load path only when idle, so they never collide
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[rd_q] <= alu_res;
    end else if (init_we && in_ready) begin
      regs[init_addr] <= init_data;
    end
  end

  // done is the registered writeback strobe, so it coincides with in_ready returning high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) done <= 1'b0;
    else     done <= wb_en;
  end

`ifdef ALU_FLAGS_EN
  logic flag_c_nxt;
  logic flag_v_nxt;

  // Carry/borrow/overflow for the result being written back
  always_comb begin
    flag_c_nxt = 1'b0;
    flag_v_nxt = 1'b0;
    case (op_q)
      OP_ADD: begin
        flag_c_nxt = (alu_res < opa);
        flag_v_nxt = (opa[W-1] == opb[W-1]) && (alu_res[W-1] != opa[W-1]);
      end
      OP_SUB: begin
        flag_c_nxt = (opa < opb);
        flag_v_nxt = (opa[W-1] != opb[W-1]) && (alu_res[W-1] != opa[W-1]);
      end
      OP_MUL:  flag_c_nxt = |mul_product[2*W-1:W];
      default: ;
    endcase
  end

  // Flags update only at writeback and hold otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
    end else if (wb_en) begin
      flag_z <= (alu_res == '0);
      flag_c <= flag_c_nxt;
      flag_v <= flag_v_nxt;
    end
  end
`else
  logic unused_mul_hi;
  assign unused_mul_hi = ^mul_product[2*W-1:W];
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed table, hand sequences, randomized ops vs. arithmetic model.
// Latency: checks T+2 / T+W+1 done timing per op.
// Backpressure: exercises held in_valid during MUL and busy-time init writes.
module tb_alu_exec_unit;

  localparam int     W    = 12;
  localparam int     NREG = 8;
  localparam int     AW   = 3;
  localparam longint FULL = 64'd1 << W;
  localparam longint HALF = 64'd1 << (W - 1);
  localparam longint MASK = FULL - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          init_we;
  logic [AW-1:0] init_addr;
  logic [W-1:0]  init_data;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_opcode;
  logic [AW-1:0] in_rs1, in_rs2, in_rd;
  logic [AW-1:0] dbg_addr;
  logic [W-1:0]  dbg_data;
  logic          done;
`ifdef ALU_FLAGS_EN
  logic          flag_z, flag_c, flag_v;
`endif

  always #5 clk = ~clk;

  alu_exec_unit #(.W(W), .NREG(NREG)) dut (
    .clk       (clk),
    .rst       (rst),
    .init_we   (init_we),
    .init_addr (init_addr),
    .init_data (init_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opcode (in_opcode),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_rd     (in_rd),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .done      (done)
`ifdef ALU_FLAGS_EN
    ,
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_v    (flag_v)
`endif
  );

  int     vectors = 0;
  int     fails   = 0;
  longint mreg [NREG];

  typedef struct {
    int     op;
    longint a;
    longint b;
    longint exp;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic longint sx(input longint v);
    return (v >= HALF) ? v - FULL : v;
  endfunction

  // Reference result straight from the arithmetic definitions
  function automatic longint ref_res(input int op, input longint a, input longint b);
    case (op)
      0: return (a + b) & MASK;
      1: return (a - b) & MASK;
      2: return a & b;
      3: return (a * b) & MASK;
      4: return a | b;
      5: return a ^ b;
      6: return (b >= W) ? 0 : ((a << b) & MASK);
      default: return (b >= W) ? 0 : (a >> b);
    endcase
  endfunction

  // Reference {Z,C,V}
  function automatic logic [2:0] ref_flags(input int op, input longint a, input longint b);
    longint r, s;
    logic c, v;
    r = ref_res(op, a, b);
    c = 1'b0;
    v = 1'b0;
    if (op == 0) begin
      c = ((a + b) >= FULL);
      s = sx(a) + sx(b);
      v = (s < -HALF) || (s >= HALF);
    end else if (op == 1) begin
      c = (a < b);
      s = sx(a) - sx(b);
      v = (s < -HALF) || (s >= HALF);
    end else if (op == 3) begin
      c = ((a * b) >= FULL);
    end
    return {(r == 0), c, v};
  endfunction

  task automatic do_reset;
    rst = 1'b1;
    init_we = 1'b0; init_addr = '0; init_data = '0;
    in_valid = 1'b0; in_opcode = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NREG; i++) mreg[i] = 0;
  endtask

  task automatic init_reg(input int addr, input longint data);
    @(negedge clk);
    init_we = 1'b1; init_addr = 3'(addr); init_data = 12'(data);
    @(negedge clk);
    init_we = 1'b0;
    mreg[addr] = data;
  endtask

  task automatic read_reg(input int addr, output logic [W-1:0] val);
    dbg_addr = 3'(addr);
    #1 val = dbg_data;
  endtask

  // Issue one op (optionally with a same-edge init write) and check timing, result and flags
  task automatic run_op(input int op, input int rd, input int rs1, input int rs2,
                        input bit iw, input int ia, input longint idat);
    longint     a, b, res;
    logic [2:0] fl;
    logic [W-1:0] rv;
    int         lat, exp_lat;
    bit         rdy_bad;
    a = mreg[rs1];
    b = mreg[rs2];
    res = ref_res(op, a, b);
    fl = ref_flags(op, a, b);
    exp_lat = (op == 3) ? W + 1 : 2;
    @(negedge clk);
    check("ready_idle", in_ready, 1);
    in_valid = 1'b1; in_opcode = 3'(op);
    in_rs1 = 3'(rs1); in_rs2 = 3'(rs2); in_rd = 3'(rd);
    init_we = iw; init_addr = 3'(ia); init_data = 12'(idat);
    @(posedge clk);
    #1 in_valid = 1'b0; init_we = 1'b0;
    if (iw) mreg[ia] = idat;
    lat = 0;
    rdy_bad = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (iw && k == 1) begin
        read_reg(ia, rv);
        check("init_visible", rv, idat);
      end
      if (done) begin
        lat = k;
        break;
      end
      if (in_ready) rdy_bad = 1;
    end
    check($sformatf("latency op%0d", op), lat, exp_lat);
    check("ready_low_busy", rdy_bad, 0);
    check("ready_at_done", in_ready, 1);
    mreg[rd] = res;
    read_reg(rd, rv);
    check($sformatf("result op%0d a=%0h b=%0h", op, a, b), rv, res);
`ifdef ALU_FLAGS_EN
    check("flags", {flag_z, flag_c, flag_v}, fl);
`endif
    @(negedge clk);
    check("done_one_cycle", done, 0);
  endtask

  logic [W-1:0] rv;
  int qop [2], qrd [2], qrs1 [2], qrs2 [2], acc_cyc [2];
  int idx, ndone, lat;
  bit rdy;

  initial begin
    tbl[0]  = '{0, 64'hFFF, 64'hFFF, 64'hFFE};
    tbl[1]  = '{0, 64'h7FF, 64'h001, 64'h800};
    tbl[2]  = '{1, 64'h000, 64'h001, 64'hFFF};
    tbl[3]  = '{1, 64'h123, 64'h123, 64'h000};
    tbl[4]  = '{2, 64'hF0F, 64'h3C3, 64'h303};
    tbl[5]  = '{4, 64'hF00, 64'h00F, 64'hF0F};
    tbl[6]  = '{5, 64'hAAA, 64'hFFF, 64'h555};
    tbl[7]  = '{3, 64'h01F, 64'h002, 64'h03E};
    tbl[8]  = '{3, 64'hFFF, 64'hFFF, 64'h001};
    tbl[9]  = '{6, 64'h001, 64'h00B, 64'h800};
    tbl[10] = '{6, 64'h001, 64'h00C, 64'h000};
    tbl[11] = '{7, 64'h800, 64'h001, 64'h400};
    tbl[12] = '{7, 64'hFFF, 64'hFFF, 64'h000};

    dbg_addr = '0;
    do_reset();

    // Reset state
    @(negedge clk);
    check("reset_ready", in_ready, 1);
    check("reset_done", done, 0);
    for (int i = 0; i < NREG; i++) begin
      read_reg(i, rv);
      check($sformatf("reset_r%0d", i), rv, 0);
    end
`ifdef ALU_FLAGS_EN
    check("reset_flags", {flag_z, flag_c, flag_v}, 3'b000);
`endif

    // Directed table
    for (int i = 0; i < 13; i++) begin
      init_reg(1, tbl[i].a);
      init_reg(2, tbl[i].b);
      run_op(tbl[i].op, 3, 1, 2, 0, 0, 0);
      read_reg(3, rv);
      check($sformatf("table%0d", i), rv, tbl[i].exp);
    end

    // Named scenarios: MUL, ADD wrap, SUB to zero, shift corners
    init_reg(0, 64'h01F);
    init_reg(1, 64'h002);
    run_op(3, 4, 0, 1, 0, 0, 0);
    init_reg(3, 64'hFFF);
    run_op(0, 2, 3, 3, 0, 0, 0);
    run_op(1, 5, 1, 1, 0, 0, 0);
    init_reg(7, 12);
    run_op(6, 6, 1, 7, 0, 0, 0);
    init_reg(6, 64'h800);
    init_reg(7, 1);
    run_op(7, 6, 6, 7, 0, 0, 0);
    read_reg(6, rv);
    check("srl_800", rv, 64'h400);

    // Held in_valid during MUL: second op waits for in_ready
    init_reg(1, 3);
    qop  = '{3, 0}; qrd = '{4, 5}; qrs1 = '{0, 4}; qrs2 = '{1, 0};
    acc_cyc = '{0, 0};
    idx = 0;
    ndone = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (done) ndone++;
      if (idx < 2) begin
        in_valid = 1'b1; in_opcode = 3'(qop[idx]);
        in_rd = 3'(qrd[idx]); in_rs1 = 3'(qrs1[idx]); in_rs2 = 3'(qrs2[idx]);
      end else begin
        in_valid = 1'b0;
      end
      rdy = in_ready;
      @(posedge clk);
      if (rdy && in_valid && idx < 2) begin
        acc_cyc[idx] = c;
        idx++;
      end
    end
    in_valid = 1'b0;
    mreg[4] = ref_res(3, mreg[0], mreg[1]);
    mreg[5] = ref_res(0, mreg[4], mreg[0]);
    check("queued_accepts", idx, 2);
    check("queued_gap", acc_cyc[1] - acc_cyc[0], W + 1);
    check("queued_dones", ndone, 2);
    read_reg(4, rv);
    check("queued_mul", rv, mreg[4]);
    read_reg(5, rv);
    check("queued_add", rv, mreg[5]);

    // init_we while busy is ignored
    @(negedge clk);
    in_valid = 1'b1; in_opcode = 3'd3; in_rd = 3'd6; in_rs1 = 3'd0; in_rs2 = 3'd1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    init_we = 1'b1; init_addr = 3'd7; init_data = 12'h5A5;
    @(negedge clk);
    init_we = 1'b0;
    lat = 0;
    for (int k = 3; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
    check("busy_init_latency", lat, W + 1);
    mreg[6] = ref_res(3, mreg[0], mreg[1]);
    read_reg(7, rv);
    check("busy_init_ignored", rv, mreg[7]);
    read_reg(6, rv);
    check("busy_mul_result", rv, mreg[6]);

    // Reset in the middle of a MUL aborts it
    @(negedge clk);
    in_valid = 1'b1; in_opcode = 3'd3; in_rd = 3'd5; in_rs1 = 3'd0; in_rs2 = 3'd1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NREG; i++) mreg[i] = 0;
    ndone = 0;
    for (int k = 0; k < W + 4; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    check("abort_ready", in_ready, 1);
    read_reg(5, rv);
    check("abort_rd_kept", rv, 0);

    // Same-edge init write and accept: op sees the old value
    init_reg(1, 5);
    run_op(0, 2, 1, 1, 1, 1, 9);
    read_reg(2, rv);
    check("same_edge_old", rv, 64'h00A);

    // Randomized ops against the model
    for (int i = 0; i < NREG; i++) init_reg(i, longint'($urandom_range(0, 4095)));
    for (int n = 0; n < 120; n++) begin
      int     op, rd, rs1, rs2, ia;
      bit     iw;
      longint idat;
      op   = $urandom_range(0, 7);
      rd   = $urandom_range(0, NREG - 1);
      rs1  = $urandom_range(0, NREG - 1);
      rs2  = $urandom_range(0, NREG - 1);
      iw   = ($urandom_range(0, 3) == 0);
      ia   = $urandom_range(0, NREG - 1);
      idat = ($urandom_range(0, 1) == 0) ? longint'($urandom_range(0, 13))
                                         : longint'($urandom_range(0, 4095));
      run_op(op, rd, rs1, rs2, iw, ia, idat);
    end
    for (int i = 0; i < NREG; i++) begin
      read_reg(i, rv);
      check($sformatf("final_r%0d", i), rv, mreg[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $fatal(1);
  end

endmodule
